// File: rtl/qc_shift_pkg.sv
// Shared helpers for the variable-Z circular shifter: level/stage counts and a
// bit-indexed reference rotate for MAXZ up to 64.
package qc_shift_pkg;

  function automatic int sw_of(input int maxz);
    return (maxz <= 2) ? 1 : $clog2(maxz);
  endfunction

  function automatic int nst_of(input int sw, input int lps);
    return (sw + lps - 1) / lps;
  endfunction

  // Bit-by-bit definition of the rotate; illegal z/s give zero.
  function automatic logic [63:0] ref_rot(input logic [63:0] d, input int z,
                                          input int s, input logic left);
    logic [63:0] r;
    int idx;
    r = '0;
    if (z < 1 || z > 64 || s < 0 || s >= z) return r;
    for (int i = 0; i < z; i++) begin
      idx = left ? (i - s + z) % z : (i + s) % z;
      r[i] = d[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/qc_shift_stage.sv
// One pipeline slot of the barrel: applies up to NLEV log-shifter levels,
// starting at level FIRST, to both rotate operands and registers the result.
module qc_shift_stage
  import qc_shift_pkg::*;
#(
  parameter int MAXZ  = 16,
  parameter int FIRST = 0,
  parameter int NLEV  = 2,
  parameter type stage_t = logic,
  localparam int SW = sw_of(MAXZ)
) (
  input  logic   CLK,
  input  logic   rst,
  input  logic   adv,
  input  stage_t d_i,
  output stage_t q_o
);

  // The last stage may own fewer than NLEV levels.
  localparam int NV = (SW - FIRST < NLEV) ? (SW - FIRST) : NLEV;

  stage_t cur;

  always_comb begin
    cur = d_i;
    for (int k = 0; k < NV; k++) begin
      if (cur.rs[FIRST+k]) cur.dr = cur.dr >> (1 << (FIRST + k));
      if (cur.ls[FIRST+k]) cur.dl = cur.dl << (1 << (FIRST + k));
    end
  end

  always_ff @(posedge CLK) begin
    if (rst)      q_o <= '0;
    else if (adv) q_o <= cur;
  end

endmodule

// File: rtl/qc_varz_shifter.sv
// Pipelined variable-Z circular shifter with valid/ready and a tag sideband.
// Left rotation (in_dir port) exists only when QCSHIFT_DIR_EN is defined.
module qc_varz_shifter
  import qc_shift_pkg::*;
#(
  parameter int MAXZ             = 16,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAGW             = 8,
  localparam int SW = sw_of(MAXZ)
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MAXZ-1:0] in_data,
  input  logic [SW:0]     in_z,
  input  logic [SW-1:0]   in_shift,
  input  logic [TAGW-1:0] in_tag,
`ifdef QCSHIFT_DIR_EN
  input  logic            in_dir,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MAXZ-1:0] out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err
);

  localparam int NST = nst_of(SW, LEVELS_PER_STAGE);
  localparam logic [SW:0] ZMAX = (SW+1)'(MAXZ);

  // dr carries d >> s, dl carries d << (z - s); both are OR-ed at the end.
  typedef struct packed {
    logic [MAXZ-1:0] dr;
    logic [MAXZ-1:0] dl;
    logic [MAXZ-1:0] mask;
    logic [SW:0]     z;
    logic [SW-1:0]   rs;
    logic [SW-1:0]   ls;
    logic [TAGW-1:0] tag;
    logic            err;
    logic            dir;
  } stage_t;

  logic            adv;
  logic [NST:0]    vld_pipe;
  logic            dir_c;
  logic            err_c;
  logic [SW-1:0]   s_eff;
  logic [MAXZ-1:0] mask_c;
  logic [MAXZ-1:0] d_c;
  stage_t          in_p;
  stage_t          in_q;
  stage_t          chain [0:NST];
  stage_t          last;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

`ifdef QCSHIFT_DIR_EN
  assign dir_c = in_dir;
`else
  assign dir_c = 1'b0;
`endif

  always_comb begin
    err_c = (in_z == '0) || (in_z > ZMAX) || ({1'b0, in_shift} >= in_z);
    for (int i = 0; i < MAXZ; i++) mask_c[i] = ((SW+1)'(i) < in_z);
    d_c = in_data & mask_c;
`ifdef QCSHIFT_DIR_EN
    // Left by s equals right by (z - s) mod z.
    s_eff = (dir_c && in_shift != '0) ? SW'(in_z - {1'b0, in_shift}) : in_shift;
`else
    s_eff = in_shift;
`endif
    in_p      = '0;
    in_p.mask = mask_c;
    in_p.z    = in_z;
    in_p.rs   = s_eff;
    in_p.tag  = in_tag;
    in_p.dir  = dir_c;
    in_p.err  = err_c & in_valid;
    if (!err_c) begin
      in_p.dr = d_c;
      // s = 0 would need a shift by z; the left operand is simply empty then.
      if (s_eff != '0) begin
        in_p.dl = d_c;
        in_p.ls = SW'(in_z - {1'b0, s_eff});
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      vld_pipe <= '0;
      in_q     <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[NST-1:0], in_valid};
      in_q     <= in_p;
    end
  end

  assign chain[0] = in_q;

  for (genvar g = 0; g < NST; g++) begin : g_stg
    qc_shift_stage #(
      .MAXZ   (MAXZ),
      .FIRST  (g * LEVELS_PER_STAGE),
      .NLEV   (LEVELS_PER_STAGE),
      .stage_t(stage_t)
    ) u_stg (
      .CLK (CLK),
      .rst (rst),
      .adv (adv),
      .d_i (chain[g]),
      .q_o (chain[g+1])
    );
  end

  assign last      = chain[NST];
  assign out_valid = vld_pipe[NST];
  assign out_data  = last.err ? '0 : ((last.dr | last.dl) & last.mask);
  assign out_tag   = last.tag;
  assign out_err   = last.err;

  logic unused_fields;
  assign unused_fields = ^{last.z, last.rs, last.ls, last.dir};

endmodule

// File: tb/tb_qc_varz_shifter.sv
// Directed bench for qc_varz_shifter (MAXZ=16, 2 levels/stage, latency 3).
module tb_qc_varz_shifter;
  import qc_shift_pkg::*;

  localparam int MAXZ = 16;
  localparam int SW   = 4;
  localparam int TAGW = 8;

  logic            CLK = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [MAXZ-1:0] in_data;
  logic [SW:0]     in_z;
  logic [SW-1:0]   in_shift;
  logic [TAGW-1:0] in_tag;
`ifdef QCSHIFT_DIR_EN
  logic            in_dir;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [MAXZ-1:0] out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  qc_varz_shifter #(.MAXZ(MAXZ), .LEVELS_PER_STAGE(2), .TAGW(TAGW)) dut (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_z(in_z), .in_shift(in_shift), .in_tag(in_tag),
`ifdef QCSHIFT_DIR_EN
    .in_dir(in_dir),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_z = '0; in_shift = '0;
    in_tag = '0; out_ready = 1'b0;
`ifdef QCSHIFT_DIR_EN
    in_dir = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    @(negedge CLK); rst = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    n_cmp++; if (out_tag !== 8'h0) begin n_bad++; $display("FAIL rst_out_tag: got %h want 00", out_tag); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out_err: got %b want 0", out_err); end
    @(negedge CLK); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_c1: got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    logic ev;
    @(negedge CLK);
    in_valid = 1'b1; in_z = 5'd16; in_shift = 4'd4; in_data = 16'h00F0;
    in_tag = 8'h5A; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK); in_valid = 1'b0; #1;
      ev = (k == 3);
      n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL lat_valid_c%0d: got %b want %b", k, out_valid, ev); end
    end
    n_cmp++; if (out_data !== 16'h000F) begin n_bad++; $display("FAIL lat_data: got %h want 000f", out_data); end
    n_cmp++; if (out_tag !== 8'h5A) begin n_bad++; $display("FAIL lat_tag: got %h want 5a", out_tag); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL lat_err: got %b want 0", out_err); end
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_varz();
    int vz[3], vs[3];
    logic [15:0] vd[3], ve[3];
    int ni = 0, no = 0, cyc = 0;
    vz[0] = 8; vs[0] = 1; vd[0] = 16'hFF81; ve[0] = 16'h00C0;
    vz[1] = 4; vs[1] = 1; vd[1] = 16'h0006; ve[1] = 16'h0003;
    vz[2] = 1; vs[2] = 0; vd[2] = 16'hFFFF; ve[2] = 16'h0001;
    while (no < 3 && cyc < 50) begin
      @(negedge CLK);
      out_ready = 1'b1;
      if (ni < 3) begin
        in_valid = 1'b1; in_z = 5'(vz[ni]); in_shift = 4'(vs[ni]);
        in_data = vd[ni]; in_tag = 8'(16 + ni);
      end else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== ve[no]) begin n_bad++; $display("FAIL varz_data%0d: got %h want %h", no, out_data, ve[no]); end
        n_cmp++; if (out_tag !== 8'(16 + no)) begin n_bad++; $display("FAIL varz_tag%0d: got %h want %h", no, out_tag, 8'(16 + no)); end
        no++;
      end
      if (in_valid && in_ready) ni++;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (no != 3) begin n_bad++; $display("FAIL varz_timeout: got %0d beats want 3", no); end
  endtask

  task automatic test_illegal();
    int vz[6], vs[6];
    logic [15:0] vd[6], ve[6];
    logic        vr[6];
    int ni = 0, no = 0, cyc = 0;
    vz[0] = 8;  vs[0] = 9;  vd[0] = 16'hFFFF; ve[0] = 16'h0000; vr[0] = 1'b1;
    vz[1] = 0;  vs[1] = 0;  vd[1] = 16'hFFFF; ve[1] = 16'h0000; vr[1] = 1'b1;
    vz[2] = 17; vs[2] = 0;  vd[2] = 16'h1234; ve[2] = 16'h0000; vr[2] = 1'b1;
    vz[3] = 5;  vs[3] = 2;  vd[3] = 16'h0013; ve[3] = 16'h001C; vr[3] = 1'b0;
    vz[4] = 16; vs[4] = 15; vd[4] = 16'h0001; ve[4] = 16'h0002; vr[4] = 1'b0;
    vz[5] = 16; vs[5] = 0;  vd[5] = 16'hA5C3; ve[5] = 16'hA5C3; vr[5] = 1'b0;
    while (no < 6 && cyc < 60) begin
      @(negedge CLK);
      out_ready = 1'b1;
      if (ni < 6) begin
        in_valid = 1'b1; in_z = 5'(vz[ni]); in_shift = 4'(vs[ni]);
        in_data = vd[ni]; in_tag = 8'(32 + ni);
      end else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_err !== vr[no]) begin n_bad++; $display("FAIL ill_err%0d: got %b want %b", no, out_err, vr[no]); end
        n_cmp++; if (out_data !== ve[no]) begin n_bad++; $display("FAIL ill_data%0d: got %h want %h", no, out_data, ve[no]); end
        n_cmp++; if (out_tag !== 8'(32 + no)) begin n_bad++; $display("FAIL ill_tag%0d: got %h want %h", no, out_tag, 8'(32 + no)); end
        no++;
      end
      if (in_valid && in_ready) ni++;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (no != 6) begin n_bad++; $display("FAIL ill_timeout: got %0d beats want 6", no); end
  endtask

  task automatic test_sweep();
    logic [15:0] pats[6];
    logic [15:0] qd[$];
    int          qz[$], qs[$];
    logic [15:0] eq_d[$];
    logic [7:0]  eq_t[$];
    logic [63:0] r;
    int n, ni = 0, no = 0, cyc = 0, first_pop = -1, last_pop = -1, last_acc = -1;
    pats[0] = 16'hA5C3; pats[1] = 16'h0001; pats[2] = 16'h8000;
    pats[3] = 16'hFFFF; pats[4] = 16'h1234; pats[5] = 16'h6DB9;
    for (int p = 0; p < 6; p++)
      for (int z = 1; z <= 16; z++)
        for (int s = 0; s < z; s++) begin
          qd.push_back(pats[p]); qz.push_back(z); qs.push_back(s);
        end
    n = qd.size();
    while (no < n && cyc < n + 50) begin
      @(negedge CLK);
      out_ready = 1'b1;
      if (ni < n) begin
        in_valid = 1'b1; in_z = 5'(qz[ni]); in_shift = 4'(qs[ni]);
        in_data = qd[ni]; in_tag = 8'(ni);
      end else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        if (eq_d.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL sweep_extra: got beat tag %h want none", out_tag);
        end else begin
          n_cmp++; if (out_data !== eq_d[0]) begin n_bad++; $display("FAIL sweep_data%0d: got %h want %h", no, out_data, eq_d[0]); end
          n_cmp++; if (out_tag !== eq_t[0]) begin n_bad++; $display("FAIL sweep_tag%0d: got %h want %h", no, out_tag, eq_t[0]); end
          n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL sweep_err%0d: got %b want 0", no, out_err); end
          void'(eq_d.pop_front()); void'(eq_t.pop_front());
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        no++;
      end
      if (in_valid && in_ready) begin
        r = ref_rot({48'h0, qd[ni]}, qz[ni], qs[ni], 1'b0);
        eq_d.push_back(r[15:0]); eq_t.push_back(8'(ni));
        last_acc = cyc;
        ni++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (no != n) begin n_bad++; $display("FAIL sweep_count: got %0d want %0d", no, n); end
    n_cmp++; if (last_pop - first_pop != n - 1) begin n_bad++; $display("FAIL sweep_out_rate: got span %0d want %0d", last_pop - first_pop, n - 1); end
    n_cmp++; if (last_acc != n - 1) begin n_bad++; $display("FAIL sweep_in_rate: got last accept cycle %0d want %0d", last_acc, n - 1); end
  endtask

  task automatic test_backpressure();
    logic [15:0] ve[8];
    logic [15:0] held_d;
    logic [7:0]  held_t;
    logic        have_held = 1'b0, saw_low = 1'b0;
    int ni = 0, no = 0, cyc = 0;
    ve[0] = 16'h0001; ve[1] = 16'h8000; ve[2] = 16'h4000; ve[3] = 16'h2000;
    ve[4] = 16'h1000; ve[5] = 16'h0800; ve[6] = 16'h0400; ve[7] = 16'h0200;
    while (no < 8 && cyc < 80) begin
      @(negedge CLK);
      out_ready = !(cyc < 3 || (cyc >= 4 && cyc <= 8));
      if (ni < 8) begin
        in_valid = 1'b1; in_z = 5'd16; in_shift = 4'(ni);
        in_data = 16'h0001; in_tag = 8'(64 + ni);
      end else in_valid = 1'b0;
      #1;
      if (!out_valid && !out_ready) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_empty_adv c%0d: got %b want 1", cyc, in_ready); end
      end
      if (out_valid && !out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", cyc, in_ready); end
        if (in_ready === 1'b0) saw_low = 1'b1;
        if (have_held) begin
          n_cmp++; if (out_data !== held_d || out_tag !== held_t) begin n_bad++; $display("FAIL bp_stable c%0d: got %h/%h want %h/%h", cyc, out_data, out_tag, held_d, held_t); end
        end
        held_d = out_data; held_t = out_tag; have_held = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== ve[no]) begin n_bad++; $display("FAIL bp_data%0d: got %h want %h", no, out_data, ve[no]); end
        n_cmp++; if (out_tag !== 8'(64 + no)) begin n_bad++; $display("FAIL bp_tag%0d: got %h want %h", no, out_tag, 8'(64 + no)); end
        no++;
      end
      if (in_valid && in_ready) ni++;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (no != 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", no); end
    n_cmp++; if (saw_low !== 1'b1) begin n_bad++; $display("FAIL bp_ready_drop: got %b want 1", saw_low); end
    @(negedge CLK); out_ready = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

`ifdef QCSHIFT_DIR_EN
  task automatic test_dir();
    int vz[3], vs[3];
    logic [15:0] vd[3], ve[3];
    logic        vl[3];
    int ni = 0, no = 0, cyc = 0;
    vz[0] = 8;  vs[0] = 1; vd[0] = 16'h0081; vl[0] = 1'b1; ve[0] = 16'h0003;
    vz[1] = 16; vs[1] = 4; vd[1] = 16'h000F; vl[1] = 1'b1; ve[1] = 16'h00F0;
    vz[2] = 8;  vs[2] = 1; vd[2] = 16'h0081; vl[2] = 1'b0; ve[2] = 16'h00C0;
    while (no < 3 && cyc < 50) begin
      @(negedge CLK);
      out_ready = 1'b1;
      if (ni < 3) begin
        in_valid = 1'b1; in_z = 5'(vz[ni]); in_shift = 4'(vs[ni]);
        in_data = vd[ni]; in_dir = vl[ni]; in_tag = 8'(96 + ni);
      end else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== ve[no]) begin n_bad++; $display("FAIL dir_data%0d: got %h want %h", no, out_data, ve[no]); end
        no++;
      end
      if (in_valid && in_ready) ni++;
      cyc++;
    end
    in_valid = 1'b0; in_dir = 1'b0;
    n_cmp++; if (no != 3) begin n_bad++; $display("FAIL dir_timeout: got %0d beats want 3", no); end
  endtask
`endif

  task automatic test_reset_mid();
    int leaks = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      out_ready = 1'b1; in_valid = 1'b1; in_z = 5'd16; in_shift = 4'd1;
      in_data = 16'h00FF; in_tag = 8'(128 + c);
    end
    @(negedge CLK); in_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK); #1;
      if (out_valid !== 1'b0) leaks++;
    end
    n_cmp++; if (leaks != 0) begin n_bad++; $display("FAIL rstmid_leak: got %0d valid cycles want 0", leaks); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_varz();
    test_illegal();
    test_sweep();
    test_backpressure();
`ifdef QCSHIFT_DIR_EN
    test_dir();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
